reg_wb_ctrl: RTL and testbench
==============================

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter LD_FIFO_DEPTH, default 4, load-return FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports alu_vld/alu_trd/alu_rd/alu_data  in  1/3/5/32  ALU writeback request; no backpressure.
REQ-005 SHALL have ports ld_vld/ld_trd/ld_rd/ld_data  in  1/3/5/32  load-return writeback request.
REQ-006 SHALL have port ld_rdy  out  1  load FIFO can accept; transfer occurs when ld_vld & ld_rdy.
REQ-007 SHALL have ports init_req/init_trd_in/init_data_in  in  1/3/32  thread init request, held until acknowledged.
REQ-008 SHALL have port init_ack  out  1  one-cycle pulse, init request consumed.
REQ-009 SHALL have ports wr_en/wr_trd/reg_wr/wr_data  out  1/3/5/32  register file write port.
REQ-010 SHALL have ports init/init_trd/init_data  out  1/3/32  register file init port.
REQ-011 SHALL have port ld_cnt  out  5  current load FIFO occupancy.

Function
REQ-012 SHALL register all outputs on wr/init ports; request accepted in cycle N appears on outputs in cycle N+1.
REQ-013 SHALL give per-cycle port priority: init issue > ALU > load FIFO head; at most one of wr_en/init high per cycle.
REQ-014 SHALL pop the load FIFO head only in cycles where alu_vld=0 and no init is issued.
REQ-015 SHALL suppress wr_en when the selected destination register is r0 or r1; a suppressed FIFO head is still popped.
REQ-016 SHALL drive ld_rdy = (ld_cnt < LD_FIFO_DEPTH) & (FSM in IDLE), computed from registered state; a simultaneous pop does not raise ld_rdy while full.
REQ-017 SHALL allow simultaneous push and pop when not full; ld_cnt unchanged, order preserved (FIFO, pointers wrap modulo depth).
REQ-018 SHALL ignore ld_vld when ld_rdy=0 (no push, no error).
REQ-019 SHALL implement init FSM states IDLE, DRAIN, ISSUE.
REQ-020 SHALL transition IDLE->DRAIN when init_req=1, capturing init_trd_in/init_data_in.
REQ-021 SHALL transition DRAIN->ISSUE when ld_cnt=0 and alu_vld=0 in the same cycle; remain in DRAIN otherwise.
REQ-022 SHALL in ISSUE assert init=1 with captured trd/data for one cycle, pulse init_ack, and return to IDLE.
REQ-023 SHALL in DRAIN still service ALU writes and FIFO pops per REQ-013/014.
REQ-024 SHALL hold wr_trd/reg_wr/wr_data at last values when wr_en=0; init_trd/init_data likewise when init=0.

Reset
REQ-025 SHALL on rst=1 at a clock edge set FSM=IDLE, FIFO empty, ld_cnt=0, wr_en=0, init=0, init_ack=0, wr_trd=0, reg_wr=0, wr_data=0, init_trd=0, init_data=0.
REQ-026 SHALL discard FIFO contents and any captured init request on reset mid-operation; ld_rdy=0 during reset cycle, 1 in the following cycle.

Configuration
REQ-027 SHALL, when macro WB_DEFER_CNT_EN is defined, add port ld_defer_cnt  out  16, saturating count of cycles with ld_cnt>0 and no pop, cleared by reset; without the macro the port and counter SHALL not exist and all other behaviour is identical.

Verification
REQ-028 SHALL cover: ALU write trd=3 rd=5 data=0xDEADBEEF -> next cycle wr_en=1, wr_trd=3, reg_wr=5, wr_data=0xDEADBEEF.
REQ-029 SHALL cover: push 4 loads (rd=6..9) with alu_vld=1 continuously -> ld_rdy=0 after 4th, ld_cnt=4; drop alu_vld -> writes rd 6,7,8,9 in order on 4 consecutive cycles.
REQ-030 SHALL cover: ALU write with rd=1 and load with rd=0 -> wr_en stays 0, load popped, ld_cnt returns to 0.
REQ-031 SHALL cover: init_req trd=2 data=0x100 with 2 loads pending and alu_vld=1 -> ld_rdy=0, loads drain after alu_vld drops, then init=1 init_trd=2 init_data=0x100 and init_ack for exactly one cycle.
REQ-032 SHALL cover: rst=1 with FIFO holding 3 entries and FSM in DRAIN -> next cycle ld_cnt=0, wr_en=0, init=0, FSM IDLE, no stale writes afterward.
REQ-033 SHALL cover (WB_DEFER_CNT_EN): 1 load pending, alu_vld=1 for 10 cycles -> ld_defer_cnt=10.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: ALU and load-return arbitration with a thread init sequencer.
// Optional `WB_DEFER_CNT_EN adds a saturating ld_defer_cnt counter output.
module reg_wb_ctrl #(
  parameter int LD_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_vld,
  input  logic [2:0]  alu_trd,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_vld,
  input  logic [2:0]  ld_trd,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_rdy,
  input  logic        init_req,
  input  logic [2:0]  init_trd_in,
  input  logic [31:0] init_data_in,
  output logic        init_ack,
  output logic        wr_en,
  output logic [2:0]  wr_trd,
  output logic [4:0]  reg_wr,
  output logic [31:0] wr_data,
  output logic        init,
  output logic [2:0]  init_trd,
  output logic [31:0] init_data,
  output logic [4:0]  ld_cnt
`ifdef WB_DEFER_CNT_EN
  ,
  output logic [15:0] ld_defer_cnt
`endif
);

  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ISSUE} state_t;

  typedef struct packed {
    logic [2:0]  trd;
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_entry_t;

  ld_entry_t        r_mem [LD_FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [4:0]       r_cnt;
  state_t           r_state;
  state_t           w_next_state;
  logic             w_capture;
  logic [2:0]       r_cap_trd;
  logic [31:0]      r_cap_data;

  logic             r_wr_en;
  logic [2:0]       r_wr_trd;
  logic [4:0]       r_reg_wr;
  logic [31:0]      r_wr_data;
  logic             r_init;
  logic             r_init_ack;
  logic [2:0]       r_init_trd;
  logic [31:0]      r_init_data;

  logic             w_issue;
  logic             w_ld_rdy;
  logic             w_push;
  logic             w_pop;
  ld_entry_t        w_head;
  logic             w_sel_vld;
  logic [2:0]       w_sel_trd;
  logic [4:0]       w_sel_rd;
  logic [31:0]      w_sel_data;
  logic             w_wr;

  assign w_issue  = (r_state == ST_ISSUE);
  assign w_ld_rdy = ~rst & (r_cnt < 5'(LD_FIFO_DEPTH)) & (r_state == ST_IDLE);
  assign w_push   = ld_vld & w_ld_rdy;
  assign w_pop    = (r_cnt != 5'd0) & ~alu_vld & ~w_issue;
  assign w_head   = r_mem[r_rptr];

  // The ack cycle blocks re-capture so a requester still holding init_req is not served twice.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_req && !r_init_ack) begin
          w_next_state = ST_DRAIN;
          w_capture    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if ((r_cnt == 5'd0) && !alu_vld) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_trd  <= '0;
      r_cap_data <= '0;
    end else if (w_capture) begin
      r_cap_trd  <= init_trd_in;
      r_cap_data <= init_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{trd: ld_trd, rd: ld_rd, data: ld_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= r_cnt + 5'(w_push) - 5'(w_pop);
    end
  end

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_trd  = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (!w_issue) begin
      if (alu_vld) begin
        w_sel_vld  = 1'b1;
        w_sel_trd  = alu_trd;
        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
      end else if (w_pop) begin
        w_sel_vld  = 1'b1;
        w_sel_trd  = w_head.trd;
        w_sel_rd   = w_head.rd;
        w_sel_data = w_head.data;
      end
    end
  end

  // r0 and r1 are architecturally fixed, so writes to them are dropped here.
  assign w_wr = w_sel_vld & (w_sel_rd > 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en     <= 1'b0;
      r_wr_trd    <= '0;
      r_reg_wr    <= '0;
      r_wr_data   <= '0;
      r_init      <= 1'b0;
      r_init_ack  <= 1'b0;
      r_init_trd  <= '0;
      r_init_data <= '0;
    end else begin
      r_wr_en    <= w_wr;
      r_init     <= w_issue;
      r_init_ack <= w_issue;
      if (w_wr) begin
        r_wr_trd  <= w_sel_trd;
        r_reg_wr  <= w_sel_rd;
        r_wr_data <= w_sel_data;
      end
      if (w_issue) begin
        r_init_trd  <= r_cap_trd;
        r_init_data <= r_cap_data;
      end
    end
  end

`ifdef WB_DEFER_CNT_EN
  logic [15:0] r_defer_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_defer_cnt <= '0;
    else if ((r_cnt != 5'd0) && !w_pop && (r_defer_cnt != 16'hFFFF))
      r_defer_cnt <= r_defer_cnt + 16'd1;
  end

  assign ld_defer_cnt = r_defer_cnt;
`endif

  assign ld_rdy    = w_ld_rdy;
  assign ld_cnt    = r_cnt;
  assign wr_en     = r_wr_en;
  assign wr_trd    = r_wr_trd;
  assign reg_wr    = r_reg_wr;
  assign wr_data   = r_wr_data;
  assign init      = r_init;
  assign init_ack  = r_init_ack;
  assign init_trd  = r_init_trd;
  assign init_data = r_init_data;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed vector table, corner sequences, random vs queue model.
module tb_reg_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld;
  logic [2:0]  alu_trd;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_vld;
  logic [2:0]  ld_trd;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_rdy;
  logic        init_req;
  logic [2:0]  init_trd_in;
  logic [31:0] init_data_in;
  logic        init_ack;
  logic        wr_en;
  logic [2:0]  wr_trd;
  logic [4:0]  reg_wr;
  logic [31:0] wr_data;
  logic        init;
  logic [2:0]  init_trd;
  logic [31:0] init_data;
  logic [4:0]  ld_cnt;
`ifdef WB_DEFER_CNT_EN
  logic [15:0] ld_defer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_ctrl #(.LD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_trd(alu_trd), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_vld(ld_vld), .ld_trd(ld_trd), .ld_rd(ld_rd), .ld_data(ld_data), .ld_rdy(ld_rdy),
    .init_req(init_req), .init_trd_in(init_trd_in), .init_data_in(init_data_in),
    .init_ack(init_ack),
    .wr_en(wr_en), .wr_trd(wr_trd), .reg_wr(reg_wr), .wr_data(wr_data),
    .init(init), .init_trd(init_trd), .init_data(init_data), .ld_cnt(ld_cnt)
`ifdef WB_DEFER_CNT_EN
    , .ld_defer_cnt(ld_defer_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        aluVld;
    logic [2:0]  aluTrd;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldVld;
    logic [2:0]  ldTrd;
    logic [4:0]  ldRd;
    logic [31:0] ldData;
    logic        expWrEn;
    logic [2:0]  expWrTrd;
    logic [4:0]  expRegWr;
    logic [31:0] expWrData;
    logic [4:0]  expCnt;
    logic        expRdy;
  } vec_t;

  typedef struct packed {
    logic [2:0]  trd;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  function automatic vec_t mk(input logic r, input logic av, input logic [2:0] at,
                              input logic [4:0] ar, input logic [31:0] ad, input logic lv,
                              input logic [2:0] lt, input logic [4:0] lr, input logic [31:0] ldd,
                              input logic ewe, input logic [2:0] ewt, input logic [4:0] erw,
                              input logic [31:0] ewd, input logic [4:0] ec, input logic er);
    vec_t v;
    v.rst = r; v.aluVld = av; v.aluTrd = at; v.aluRd = ar; v.aluData = ad;
    v.ldVld = lv; v.ldTrd = lt; v.ldRd = lr; v.ldData = ldd;
    v.expWrEn = ewe; v.expWrTrd = ewt; v.expRegWr = erw; v.expWrData = ewd;
    v.expCnt = ec; v.expRdy = er;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    alu_vld  = v.aluVld;
    alu_trd  = v.aluTrd;
    alu_rd   = v.aluRd;
    alu_data = v.aluData;
    ld_vld   = v.ldVld;
    ld_trd   = v.ldTrd;
    ld_rd    = v.ldRd;
    ld_data  = v.ldData;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    alu_vld = 0; alu_trd = 0; alu_rd = 0; alu_data = 0;
    ld_vld = 0; ld_trd = 0; ld_rd = 0; ld_data = 0;
    init_req = 0; init_trd_in = 0; init_data_in = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic runTable();
    vec_t vecs[16];
    vecs[0]  = mk(1, 0,0,0,0,            0,0,0,0,          0,0,0,0,            0,0);
    vecs[1]  = mk(0, 0,0,0,0,            0,0,0,0,          0,0,0,0,            0,1);
    vecs[2]  = mk(0, 1,3,5,32'hDEADBEEF, 0,0,0,0,          1,3,5,32'hDEADBEEF, 0,1);
    vecs[3]  = mk(0, 1,1,10,32'h11,      1,2,6,32'h600,    1,1,10,32'h11,      1,1);
    vecs[4]  = mk(0, 1,1,11,32'h22,      1,2,7,32'h700,    1,1,11,32'h22,      2,1);
    vecs[5]  = mk(0, 1,1,12,32'h33,      1,2,8,32'h800,    1,1,12,32'h33,      3,1);
    vecs[6]  = mk(0, 1,1,13,32'h44,      1,2,9,32'h900,    1,1,13,32'h44,      4,0);
    vecs[7]  = mk(0, 1,1,14,32'h55,      1,2,20,32'h2000,  1,1,14,32'h55,      4,0);
    vecs[8]  = mk(0, 0,0,0,0,            0,0,0,0,          1,2,6,32'h600,      3,1);
    vecs[9]  = mk(0, 0,0,0,0,            0,0,0,0,          1,2,7,32'h700,      2,1);
    vecs[10] = mk(0, 0,0,0,0,            0,0,0,0,          1,2,8,32'h800,      1,1);
    vecs[11] = mk(0, 0,0,0,0,            0,0,0,0,          1,2,9,32'h900,      0,1);
    vecs[12] = mk(0, 0,0,0,0,            0,0,0,0,          0,2,9,32'h900,      0,1);
    vecs[13] = mk(0, 1,4,1,32'hAAAA,     1,5,0,32'hBBBB,   0,2,9,32'h900,      1,1);
    vecs[14] = mk(0, 0,0,0,0,            0,0,0,0,          0,2,9,32'h900,      0,1);
    vecs[15] = mk(0, 0,0,0,0,            0,0,0,0,          0,2,9,32'h900,      0,1);
    clearInputs();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d wr_en", i),   32'(wr_en),   32'(vecs[i].expWrEn));
      checkOutput($sformatf("vec%0d wr_trd", i),  32'(wr_trd),  32'(vecs[i].expWrTrd));
      checkOutput($sformatf("vec%0d reg_wr", i),  32'(reg_wr),  32'(vecs[i].expRegWr));
      checkOutput($sformatf("vec%0d wr_data", i), wr_data,      vecs[i].expWrData);
      checkOutput($sformatf("vec%0d ld_cnt", i),  32'(ld_cnt),  32'(vecs[i].expCnt));
      checkOutput($sformatf("vec%0d ld_rdy", i),  32'(ld_rdy),  32'(vecs[i].expRdy));
      checkOutput($sformatf("vec%0d init", i),    32'(init),    32'h0);
    end
  endtask

  task automatic runInitDrain();
    int wrLog[$];
    int ackCycles;
    doReset();
    alu_vld = 1; alu_trd = 0; alu_rd = 15; alu_data = 32'h1;
    ld_vld = 1; ld_trd = 2; ld_rd = 20; ld_data = 32'h2000;
    tick();
    ld_rd = 21; ld_data = 32'h2100;
    tick();
    ld_vld = 0;
    init_req = 1; init_trd_in = 2; init_data_in = 32'h100;
    tick();
    checkOutput("drain ld_rdy", 32'(ld_rdy), 32'h0);
    checkOutput("drain ld_cnt", 32'(ld_cnt), 32'h2);
    tick();
    checkOutput("drain hold ld_cnt", 32'(ld_cnt), 32'h2);
    checkOutput("drain hold init", 32'(init), 32'h0);
    alu_vld = 0;
    ackCycles = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("drain exclusive", 32'(wr_en & init), 32'h0);
      if (wr_en) wrLog.push_back(int'(reg_wr));
      if (init_ack) begin
        ackCycles++;
        checkOutput("init pulse", 32'(init), 32'h1);
        checkOutput("init_trd", 32'(init_trd), 32'h2);
        checkOutput("init_data", init_data, 32'h100);
        checkOutput("loads before init", 32'(wrLog.size()), 32'h2);
        init_req = 0;
      end
    end
    checkOutput("init_ack cycles", 32'(ackCycles), 32'h1);
    checkOutput("drained writes", 32'(wrLog.size()), 32'h2);
    if (wrLog.size() == 2) begin
      checkOutput("drain order 0", 32'(wrLog[0]), 32'd20);
      checkOutput("drain order 1", 32'(wrLog[1]), 32'd21);
    end
    init_req = 0;
  endtask

  task automatic runMidReset();
    int stale;
    doReset();
    alu_vld = 1; alu_rd = 15; alu_data = 32'h7;
    ld_vld = 1; ld_trd = 3;
    for (int k = 0; k < 3; k++) begin
      ld_rd = 5'(22 + k); ld_data = 32'(k + 1);
      tick();
    end
    ld_vld = 0;
    init_req = 1; init_trd_in = 1; init_data_in = 32'h55;
    tick();
    checkOutput("midrst pre ld_cnt", 32'(ld_cnt), 32'h3);
    checkOutput("midrst pre ld_rdy", 32'(ld_rdy), 32'h0);
    rst = 1; alu_vld = 0; init_req = 0;
    tick();
    checkOutput("midrst ld_cnt", 32'(ld_cnt), 32'h0);
    checkOutput("midrst wr_en", 32'(wr_en), 32'h0);
    checkOutput("midrst init", 32'(init), 32'h0);
    checkOutput("midrst wr_data", wr_data, 32'h0);
    checkOutput("midrst ld_rdy in reset", 32'(ld_rdy), 32'h0);
    rst = 0;
    #1;
    checkOutput("midrst ld_rdy after", 32'(ld_rdy), 32'h1);
    stale = 0;
    repeat (6) begin
      tick();
      if (wr_en || init || init_ack) stale++;
    end
    checkOutput("midrst stale writes", 32'(stale), 32'h0);
    checkOutput("midrst ld_cnt idle", 32'(ld_cnt), 32'h0);
  endtask

`ifdef WB_DEFER_CNT_EN
  task automatic runDefer();
    doReset();
    alu_vld = 1; alu_rd = 15; alu_data = 32'h9;
    ld_vld = 1; ld_trd = 1; ld_rd = 25; ld_data = 32'h25;
    tick();
    ld_vld = 0;
    repeat (10) tick();
    checkOutput("defer count", 32'(ld_defer_cnt), 32'd10);
    alu_vld = 0;
    tick();
    checkOutput("defer after pop", 32'(ld_defer_cnt), 32'd10);
  endtask
`endif

  // Reference: a queue of pending loads plus a pending/issuing init request, updated per cycle.
  task automatic runRandom();
    ent_t q[$];
    ent_t sel;
    logic mPend, mIssuing, mRdy, hasSel, popped, issueNow, ackPrev, reqOn;
    logic [2:0] mCapTrd, reqTrd;
    logic [31:0] mCapData, reqData;
    logic mWrEn, mInit, mAck;
    logic [2:0] mWrTrd, mInitTrd;
    logic [4:0] mRegWr;
    logic [31:0] mWrData, mInitData;
    int mDefer, preSize;
    doReset();
    q.delete();
    mPend = 0; mIssuing = 0; reqOn = 0; mCapTrd = 0; mCapData = 0; reqTrd = 0; reqData = 0;
    mWrEn = 0; mInit = 0; mAck = 0; mWrTrd = 0; mInitTrd = 0; mRegWr = 0;
    mWrData = 0; mInitData = 0; mDefer = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst      = ($urandom_range(0, 299) == 0);
      alu_vld  = ($urandom_range(0, 99) < 45);
      alu_trd  = 3'($urandom_range(0, 7));
      alu_rd   = 5'($urandom_range(0, 31));
      alu_data = $urandom();
      ld_vld   = ($urandom_range(0, 99) < 50);
      ld_trd   = 3'($urandom_range(0, 7));
      ld_rd    = 5'($urandom_range(0, 31));
      ld_data  = $urandom();
      if (rst) reqOn = 0;
      else if (!reqOn && $urandom_range(0, 39) == 0) begin
        reqOn = 1;
        reqTrd = 3'($urandom_range(0, 7));
        reqData = $urandom();
      end
      init_req = reqOn; init_trd_in = reqTrd; init_data_in = reqData;
      #1;
      mRdy = !rst && (q.size() < DEPTH) && !mPend && !mIssuing;
      checkOutput("rnd ld_rdy", 32'(ld_rdy), 32'(mRdy));
      if (rst) begin
        q.delete();
        mPend = 0; mIssuing = 0;
        mWrEn = 0; mInit = 0; mAck = 0; mWrTrd = 0; mRegWr = 0; mWrData = 0;
        mInitTrd = 0; mInitData = 0; mDefer = 0;
      end else begin
        preSize = q.size();
        issueNow = mIssuing;
        ackPrev = mAck;
        popped = 0; hasSel = 0; sel = '0;
        mWrEn = 0; mInit = 0; mAck = 0;
        if (issueNow) begin
          mInit = 1; mAck = 1; mInitTrd = mCapTrd; mInitData = mCapData;
          mIssuing = 0;
        end else if (alu_vld) begin
          hasSel = 1; sel = '{trd: alu_trd, rd: alu_rd, data: alu_data};
        end else if (preSize > 0) begin
          hasSel = 1; sel = q.pop_front(); popped = 1;
        end
        if (hasSel && sel.rd > 1) begin
          mWrEn = 1; mWrTrd = sel.trd; mRegWr = sel.rd; mWrData = sel.data;
        end
        if (ld_vld && mRdy) q.push_back('{trd: ld_trd, rd: ld_rd, data: ld_data});
        if (preSize > 0 && !popped && mDefer < 65535) mDefer++;
        if (mPend && preSize == 0 && !alu_vld) begin
          mPend = 0; mIssuing = 1;
        end else if (!mPend && !issueNow && !ackPrev && init_req) begin
          mPend = 1; mCapTrd = init_trd_in; mCapData = init_data_in;
        end
      end
      @(posedge clk);
      #1;
      checkOutput("rnd wr_en", 32'(wr_en), 32'(mWrEn));
      checkOutput("rnd wr_trd", 32'(wr_trd), 32'(mWrTrd));
      checkOutput("rnd reg_wr", 32'(reg_wr), 32'(mRegWr));
      checkOutput("rnd wr_data", wr_data, mWrData);
      checkOutput("rnd init", 32'(init), 32'(mInit));
      checkOutput("rnd init_ack", 32'(init_ack), 32'(mAck));
      checkOutput("rnd init_trd", 32'(init_trd), 32'(mInitTrd));
      checkOutput("rnd init_data", init_data, mInitData);
      checkOutput("rnd ld_cnt", 32'(ld_cnt), 32'(q.size()));
`ifdef WB_DEFER_CNT_EN
      checkOutput("rnd ld_defer_cnt", 32'(ld_defer_cnt), 32'(mDefer));
`endif
      if (mAck) reqOn = 0;
    end
    rst = 0;
    clearInputs();
  endtask

  initial begin
    rst = 1;
    clearInputs();
    runTable();
    runInitDrain();
    runMidReset();
`ifdef WB_DEFER_CNT_EN
    runDefer();
`endif
    runRandom();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
